id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameters: DATA_W, default 32, datapath width; REG_ADDR_W, default 5, register-number width; CNT_W, default 16, bubble-counter width.
REQ-002 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port Rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have decode-side inputs: In_valid 1, the instruction in decode is real; Read_data1/Read_data2 DATA_W, register-file read ports; Rs/Rt/Rd REG_ADDR_W; Imm DATA_W, sign-extended immediate.
REQ-005 SHALL have control inputs (1 bit each): Reg_write, Mem_read, Mem_write, Mem_to_reg, Alu_src, Reg_dst; plus Alu_op, 4 bits.
REQ-006 SHALL have pipeline inputs (1 bit each): Stall, hold all stage state; Flush, kill the stage.
REQ-007 SHALL have write-back bypass inputs: Wb_reg_write 1; Wb_write_reg REG_ADDR_W; Wb_write_data DATA_W.
REQ-008 SHALL have registered outputs: Ex_valid 1; Ex_data1/Ex_data2 DATA_W; Ex_imm DATA_W; Ex_rs/Ex_rt/Ex_dest REG_ADDR_W; Ex_ copies of all REQ-005 controls.
REQ-009 SHALL have outputs Load_use_stall 1 (combinational, to fetch/decode hold) and Bubble_count CNT_W (registered).

Function
REQ-010 Load_use_stall SHALL = Ex_valid & Ex_mem_read & (Ex_rt!=0) & In_valid & (Ex_rt==Rs | Ex_rt==Rt).
REQ-011 Each rising edge SHALL apply exactly one action, priority: reset > Flush > Stall > Load_use_stall (bubble) > load.
REQ-012 Flush SHALL clear Ex_valid and all Ex_ controls (Alu_op=0) next edge; data/address fields hold.
REQ-013 Stall SHALL hold every output unchanged, except REQ-017 refresh; Bubble_count unchanged.
REQ-014 Bubble SHALL clear Ex_valid and all Ex_ controls, and increment Bubble_count by 1, saturating at all-ones.
REQ-015 Load SHALL capture Ex_valid=In_valid, Imm, Rs, Rt, controls; Ex_dest = Reg_dst ? Rd : Rt; latency 1 cycle.
REQ-016 On load, operand A SHALL be 0 if Rs==0; else Wb_write_data if Wb_reg_write & Wb_write_reg==Rs; else Read_data1. Operand B identical with Rt/Read_data2.
REQ-017 While Stall holds a valid entry, a write-back with Wb_reg_write & Wb_write_reg!=0 matching Ex_rs (Ex_rt) SHALL overwrite Ex_data1 (Ex_data2) with Wb_write_data.
REQ-018 Write-back to register 0 SHALL never bypass or refresh.
REQ-019 In_valid=0 on load SHALL produce Ex_valid=0 with controls cleared (bubble not counted).
REQ-020 Flush and Load_use_stall in the same cycle: flush only; Bubble_count unchanged.

Reset
REQ-021 On a rising edge with Rst_n=0, all outputs SHALL go to 0: Ex_valid, all Ex_ fields and controls, Bubble_count.
REQ-022 Reset SHALL override Stall/Flush and abort any held instruction; Load_use_stall SHALL be 0 on the first cycle after reset.

Structure
REQ-023 DATA_W/REG_ADDR_W defaults, Alu_op encodings and the control-bundle field list SHALL live in shared package mips_pkg.
REQ-024 Operand selection (REQ-016/017/018) SHALL be one sub-module id_bypass, instantiated per operand.

Verification
REQ-025 Reset, then load Rs=3, Rt=4, Read_data1=0x11, Read_data2=0x22, Reg_dst=1, Rd=7 -> next edge: Ex_data1=0x11, Ex_data2=0x22, Ex_dest=7, Ex_valid=1.
REQ-026 Load Rs=12, Read_data1=0x0, with Wb_reg_write=1, Wb_write_reg=12, Wb_write_data=0xC0A0 -> Ex_data1=0xC0A0; repeat with Wb_write_reg=0, Rs=0 -> Ex_data1=0.
REQ-027 EX holds lw (Mem_read=1, Rt=2); decode In_valid=1, Rs=2 -> Load_use_stall=1; next edge Ex_valid=0, Ex_mem_read=0, Bubble_count=1.
REQ-028 Stall=1 for 3 cycles with valid entry Ex_rs=5; WB writes reg 5 = 0xA5D604 in cycle 2 -> outputs frozen except Ex_data1=0xA5D604.
REQ-029 Flush=1 with Load_use_stall=1 -> Ex_valid=0, Bubble_count unchanged; Bubble_count preset to 0xFFFF then bubble -> stays 0xFFFF.
REQ-030 Rst_n=0 mid-stall with Ex_valid=1 -> next edge all outputs 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath defaults, ALU op encodings, control bundle.
// Pure declarations: no latency and no flow control apply here.
package mips_pkg;

    localparam int MIPS_DATA_W     = 32;
    localparam int MIPS_REG_ADDR_W = 5;
    localparam int MIPS_CNT_W      = 16;
    localparam int ALU_OP_W        = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_NOR = 4'd12
    } alu_op_e;

    // The ALU op is carried as raw bits so undecoded opcodes pass through untouched.
    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                alu_src;
        logic                reg_dst;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    function automatic ctrl_t ctrl_if_valid(input logic vld, input ctrl_t c);
        return vld ? c : CTRL_NOP;
    endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// Decode/execute boundary bundle: decode fields, controls, pipeline commands, WB bypass, EX outputs.
// Carries no state, so no latency; Stall/Flush are the only flow-control signals.
interface id_ex_reg_if
    import mips_pkg::*;
#(
    parameter int DATA_W     = MIPS_DATA_W,
    parameter int REG_ADDR_W = MIPS_REG_ADDR_W,
    parameter int CNT_W      = MIPS_CNT_W
);
    logic                  In_valid;
    logic [DATA_W-1:0]     Read_data1;
    logic [DATA_W-1:0]     Read_data2;
    logic [REG_ADDR_W-1:0] Rs;
    logic [REG_ADDR_W-1:0] Rt;
    logic [REG_ADDR_W-1:0] Rd;
    logic [DATA_W-1:0]     Imm;

    logic                  Reg_write;
    logic                  Mem_read;
    logic                  Mem_write;
    logic                  Mem_to_reg;
    logic                  Alu_src;
    logic                  Reg_dst;
    logic [ALU_OP_W-1:0]   Alu_op;

    logic                  Stall;
    logic                  Flush;

    logic                  Wb_reg_write;
    logic [REG_ADDR_W-1:0] Wb_write_reg;
    logic [DATA_W-1:0]     Wb_write_data;

    logic                  Ex_valid;
    logic [DATA_W-1:0]     Ex_data1;
    logic [DATA_W-1:0]     Ex_data2;
    logic [DATA_W-1:0]     Ex_imm;
    logic [REG_ADDR_W-1:0] Ex_rs;
    logic [REG_ADDR_W-1:0] Ex_rt;
    logic [REG_ADDR_W-1:0] Ex_dest;
    logic                  Ex_reg_write;
    logic                  Ex_mem_read;
    logic                  Ex_mem_write;
    logic                  Ex_mem_to_reg;
    logic                  Ex_alu_src;
    logic                  Ex_reg_dst;
    logic [ALU_OP_W-1:0]   Ex_alu_op;

    logic                  Load_use_stall;
    logic [CNT_W-1:0]      Bubble_count;

    modport master (
        output In_valid, Read_data1, Read_data2, Rs, Rt, Rd, Imm,
        output Reg_write, Mem_read, Mem_write, Mem_to_reg, Alu_src, Reg_dst, Alu_op,
        output Stall, Flush, Wb_reg_write, Wb_write_reg, Wb_write_data,
        input  Ex_valid, Ex_data1, Ex_data2, Ex_imm, Ex_rs, Ex_rt, Ex_dest,
        input  Ex_reg_write, Ex_mem_read, Ex_mem_write, Ex_mem_to_reg, Ex_alu_src, Ex_reg_dst, Ex_alu_op,
        input  Load_use_stall, Bubble_count
    );

    modport slave (
        input  In_valid, Read_data1, Read_data2, Rs, Rt, Rd, Imm,
        input  Reg_write, Mem_read, Mem_write, Mem_to_reg, Alu_src, Reg_dst, Alu_op,
        input  Stall, Flush, Wb_reg_write, Wb_write_reg, Wb_write_data,
        output Ex_valid, Ex_data1, Ex_data2, Ex_imm, Ex_rs, Ex_rt, Ex_dest,
        output Ex_reg_write, Ex_mem_read, Ex_mem_write, Ex_mem_to_reg, Ex_alu_src, Ex_reg_dst, Ex_alu_op,
        output Load_use_stall, Bubble_count
    );

endinterface

// File: rtl/id_bypass.sv
// Operand select for one source: load value (r0 / WB bypass / regfile) and held-entry refresh value.
// Purely combinational, 0 latency; no flow control of its own.
module id_bypass
    import mips_pkg::*;
#(
    parameter int DATA_W     = MIPS_DATA_W,
    parameter int REG_ADDR_W = MIPS_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0]     rf_dat,
    input  logic [REG_ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0]     ex_dat,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_write_reg,
    input  logic [DATA_W-1:0]     wb_write_dat,
    output logic [DATA_W-1:0]     load_dat,
    output logic [DATA_W-1:0]     hold_dat
);

    // r0 is hardwired zero, so a write-back aimed at it is never a real producer.
    logic wb_live;
    assign wb_live = wb_reg_write && (wb_write_reg != '0);

    always_comb begin
        load_dat = rf_dat;
        if (src_addr == '0) begin
            load_dat = '0;
        end else if (wb_live && (wb_write_reg == src_addr)) begin
            load_dat = wb_write_dat;
        end
    end

    always_comb begin
        hold_dat = ex_dat;
        if (wb_live && (wb_write_reg == ex_addr)) begin
            hold_dat = wb_write_dat;
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with WB bypass, load-use bubble insertion and a saturating bubble counter.
// Latency 1 cycle; Stall freezes the stage (WB refresh only), Flush kills it, load-use inserts a bubble.
module id_ex_reg
    import mips_pkg::*;
#(
    parameter int DATA_W     = MIPS_DATA_W,
    parameter int REG_ADDR_W = MIPS_REG_ADDR_W,
    parameter int CNT_W      = MIPS_CNT_W
) (
    input  logic        Clk,
    input  logic        Rst_n,
    id_ex_reg_if.slave  bus
);

    logic                  ex_valid_q;
    ctrl_t                 ex_ctrl_q;
    logic [DATA_W-1:0]     ex_data1_q;
    logic [DATA_W-1:0]     ex_data2_q;
    logic [DATA_W-1:0]     ex_imm_q;
    logic [REG_ADDR_W-1:0] ex_rs_q;
    logic [REG_ADDR_W-1:0] ex_rt_q;
    logic [REG_ADDR_W-1:0] ex_dest_q;
    logic [CNT_W-1:0]      bubble_cnt_q;

    ctrl_t                 in_ctrl;
    logic                  load_use;
    logic [DATA_W-1:0]     load_a_dat;
    logic [DATA_W-1:0]     load_b_dat;
    logic [DATA_W-1:0]     hold_a_dat;
    logic [DATA_W-1:0]     hold_b_dat;

    assign in_ctrl = '{
        reg_write:  bus.Reg_write,
        mem_read:   bus.Mem_read,
        mem_write:  bus.Mem_write,
        mem_to_reg: bus.Mem_to_reg,
        alu_src:    bus.Alu_src,
        reg_dst:    bus.Reg_dst,
        alu_op:     bus.Alu_op
    };

    // A load in EX whose target feeds the decode instruction cannot be forwarded in time.
    assign load_use = ex_valid_q && ex_ctrl_q.mem_read && (ex_rt_q != '0) && bus.In_valid
                      && ((ex_rt_q == bus.Rs) || (ex_rt_q == bus.Rt));

    id_bypass #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_byp_a (
        .src_addr     (bus.Rs),
        .rf_dat       (bus.Read_data1),
        .ex_addr      (ex_rs_q),
        .ex_dat       (ex_data1_q),
        .wb_reg_write (bus.Wb_reg_write),
        .wb_write_reg (bus.Wb_write_reg),
        .wb_write_dat (bus.Wb_write_data),
        .load_dat     (load_a_dat),
        .hold_dat     (hold_a_dat)
    );

    id_bypass #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_byp_b (
        .src_addr     (bus.Rt),
        .rf_dat       (bus.Read_data2),
        .ex_addr      (ex_rt_q),
        .ex_dat       (ex_data2_q),
        .wb_reg_write (bus.Wb_reg_write),
        .wb_write_reg (bus.Wb_write_reg),
        .wb_write_dat (bus.Wb_write_data),
        .load_dat     (load_b_dat),
        .hold_dat     (hold_b_dat)
    );

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_ctrl_q    <= CTRL_NOP;
            ex_data1_q   <= '0;
            ex_data2_q   <= '0;
            ex_imm_q     <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_dest_q    <= '0;
            bubble_cnt_q <= '0;
        end else if (bus.Flush) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= CTRL_NOP;
        end else if (bus.Stall) begin
            // Held operands must not go stale while the producer retires underneath them.
            if (ex_valid_q) begin
                ex_data1_q <= hold_a_dat;
                ex_data2_q <= hold_b_dat;
            end
        end else if (load_use) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= CTRL_NOP;
            if (bubble_cnt_q != '1) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
            end
        end else begin
            ex_valid_q <= bus.In_valid;
            ex_ctrl_q  <= ctrl_if_valid(bus.In_valid, in_ctrl);
            ex_data1_q <= load_a_dat;
            ex_data2_q <= load_b_dat;
            ex_imm_q   <= bus.Imm;
            ex_rs_q    <= bus.Rs;
            ex_rt_q    <= bus.Rt;
            ex_dest_q  <= bus.Reg_dst ? bus.Rd : bus.Rt;
        end
    end

    assign bus.Ex_valid       = ex_valid_q;
    assign bus.Ex_data1       = ex_data1_q;
    assign bus.Ex_data2       = ex_data2_q;
    assign bus.Ex_imm         = ex_imm_q;
    assign bus.Ex_rs          = ex_rs_q;
    assign bus.Ex_rt          = ex_rt_q;
    assign bus.Ex_dest        = ex_dest_q;
    assign bus.Ex_reg_write   = ex_ctrl_q.reg_write;
    assign bus.Ex_mem_read    = ex_ctrl_q.mem_read;
    assign bus.Ex_mem_write   = ex_ctrl_q.mem_write;
    assign bus.Ex_mem_to_reg  = ex_ctrl_q.mem_to_reg;
    assign bus.Ex_alu_src     = ex_ctrl_q.alu_src;
    assign bus.Ex_reg_dst     = ex_ctrl_q.reg_dst;
    assign bus.Ex_alu_op      = ex_ctrl_q.alu_op;
    assign bus.Load_use_stall = load_use;
    assign bus.Bubble_count   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: per-cycle comparison against a behavioural stage model plus literal checks.
module tb_id_ex_reg;

    logic Clk;
    logic Rst_n;
    logic s_rst_n;

    id_ex_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(16)) b ();
    id_ex_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4))  s ();

    id_ex_reg #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(16)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (b)
    );

    id_ex_reg #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4)) dut_small (
        .Clk   (Clk),
        .Rst_n (s_rst_n),
        .bus   (s)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the stage ----------------
    bit          m_known = 0;
    logic        m_valid;
    logic [9:0]  m_ctrl;
    logic [31:0] m_d1, m_d2, m_imm;
    logic [4:0]  m_rs, m_rt, m_dest;
    logic [15:0] m_cnt;

    function automatic logic [9:0] dec_ctrl();
        return {b.Reg_write, b.Mem_read, b.Mem_write, b.Mem_to_reg, b.Alu_src, b.Reg_dst, b.Alu_op};
    endfunction

    function automatic logic [9:0] ex_ctrl();
        return {b.Ex_reg_write, b.Ex_mem_read, b.Ex_mem_write, b.Ex_mem_to_reg,
                b.Ex_alu_src, b.Ex_reg_dst, b.Ex_alu_op};
    endfunction

    function automatic bit model_lus();
        return m_known && m_valid && m_ctrl[8] && (m_rt != 0) && b.In_valid
               && (m_rt == b.Rs || m_rt == b.Rt);
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf);
        if (r == 0) return 32'd0;
        if (b.Wb_reg_write && b.Wb_write_reg == r) return b.Wb_write_data;
        return rf;
    endfunction

    always @(posedge Clk) begin
        if (!Rst_n) begin
            m_known = 1;
            m_valid = 0; m_ctrl = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
            m_rs = 0; m_rt = 0; m_dest = 0; m_cnt = 0;
        end else if (m_known) begin
            if (b.Flush) begin
                m_valid = 0; m_ctrl = 0;
            end else if (b.Stall) begin
                if (m_valid && b.Wb_reg_write && b.Wb_write_reg != 0) begin
                    if (b.Wb_write_reg == m_rs) m_d1 = b.Wb_write_data;
                    if (b.Wb_write_reg == m_rt) m_d2 = b.Wb_write_data;
                end
            end else if (model_lus()) begin
                m_valid = 0; m_ctrl = 0;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
            end else begin
                m_valid = b.In_valid;
                m_ctrl  = b.In_valid ? dec_ctrl() : 10'd0;
                m_d1    = operand(b.Rs, b.Read_data1);
                m_d2    = operand(b.Rt, b.Read_data2);
                m_imm   = b.Imm;
                m_rs    = b.Rs;
                m_rt    = b.Rt;
                m_dest  = b.Reg_dst ? b.Rd : b.Rt;
            end
        end
    end

    always @(negedge Clk) begin
        if (m_known) begin
            chk("m_ex_valid", 64'(b.Ex_valid), 64'(m_valid));
            chk("m_ctrl", 64'(ex_ctrl()), 64'(m_ctrl));
            chk("m_ex_data1", 64'(b.Ex_data1), 64'(m_d1));
            chk("m_ex_data2", 64'(b.Ex_data2), 64'(m_d2));
            chk("m_ex_imm", 64'(b.Ex_imm), 64'(m_imm));
            chk("m_ex_rs", 64'(b.Ex_rs), 64'(m_rs));
            chk("m_ex_rt", 64'(b.Ex_rt), 64'(m_rt));
            chk("m_ex_dest", 64'(b.Ex_dest), 64'(m_dest));
            chk("m_bubble_count", 64'(b.Bubble_count), 64'(m_cnt));
            chk("m_load_use", 64'(b.Load_use_stall), 64'(model_lus()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        b.In_valid = 0; b.Read_data1 = 0; b.Read_data2 = 0; b.Rs = 0; b.Rt = 0; b.Rd = 0; b.Imm = 0;
        b.Reg_write = 0; b.Mem_read = 0; b.Mem_write = 0; b.Mem_to_reg = 0; b.Alu_src = 0;
        b.Reg_dst = 0; b.Alu_op = 0; b.Stall = 0; b.Flush = 0;
        b.Wb_reg_write = 0; b.Wb_write_reg = 0; b.Wb_write_data = 0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_lw(input logic [4:0] rs, input logic [4:0] rt);
        idle();
        b.In_valid = 1; b.Rs = rs; b.Rt = rt; b.Read_data1 = 32'h400; b.Imm = 32'h8;
        b.Mem_read = 1; b.Mem_to_reg = 1; b.Reg_write = 1; b.Alu_src = 1; b.Alu_op = 4'd2;
        step();
    endtask

    initial begin
        Rst_n = 0; s_rst_n = 0;
        idle();
        s.In_valid = 0; s.Read_data1 = 0; s.Read_data2 = 0; s.Rs = 0; s.Rt = 0; s.Rd = 0; s.Imm = 0;
        s.Reg_write = 0; s.Mem_read = 0; s.Mem_write = 0; s.Mem_to_reg = 0; s.Alu_src = 0;
        s.Reg_dst = 0; s.Alu_op = 0; s.Stall = 0; s.Flush = 0;
        s.Wb_reg_write = 0; s.Wb_write_reg = 0; s.Wb_write_data = 0;
        step(); step();
        chk("rst_ex_valid", 64'(b.Ex_valid), 64'd0);
        chk("rst_bubble_count", 64'(b.Bubble_count), 64'd0);
        chk("rst_load_use", 64'(b.Load_use_stall), 64'd0);
        Rst_n = 1;

        // basic load with Rd destination
        b.In_valid = 1; b.Rs = 3; b.Rt = 4; b.Read_data1 = 32'h11; b.Read_data2 = 32'h22;
        b.Reg_dst = 1; b.Rd = 7; b.Reg_write = 1; b.Alu_op = 4'd2; b.Imm = 32'h1234;
        step();
        chk("load_data1", 64'(b.Ex_data1), 64'h11);
        chk("load_data2", 64'(b.Ex_data2), 64'h22);
        chk("load_dest", 64'(b.Ex_dest), 64'd7);
        chk("load_valid", 64'(b.Ex_valid), 64'd1);

        // WB bypass, then r0 never bypassed
        idle();
        b.In_valid = 1; b.Rs = 12; b.Rt = 4; b.Read_data1 = 32'h0; b.Read_data2 = 32'h44;
        b.Wb_reg_write = 1; b.Wb_write_reg = 12; b.Wb_write_data = 32'hC0A0;
        step();
        chk("bypass_data1", 64'(b.Ex_data1), 64'hC0A0);
        b.Rs = 0; b.Wb_write_reg = 0; b.Read_data1 = 32'h55;
        step();
        chk("r0_data1", 64'(b.Ex_data1), 64'd0);

        // load-use bubble
        load_lw(5'd1, 5'd2);
        idle();
        b.In_valid = 1; b.Rs = 2; b.Rt = 9; b.Reg_write = 1;
        #1;
        chk("lu_stall_asserted", 64'(b.Load_use_stall), 64'd1);
        step();
        chk("lu_ex_valid", 64'(b.Ex_valid), 64'd0);
        chk("lu_ex_mem_read", 64'(b.Ex_mem_read), 64'd0);
        chk("lu_bubble_count", 64'(b.Bubble_count), 64'd1);
        chk("lu_released", 64'(b.Load_use_stall), 64'd0);

        // stall with WB refresh in its second cycle
        idle();
        b.In_valid = 1; b.Rs = 5; b.Rt = 6; b.Read_data1 = 32'h50; b.Read_data2 = 32'h60;
        b.Reg_write = 1; b.Alu_op = 4'd6; b.Imm = 32'hABC;
        step();
        b.Stall = 1; b.Rs = 8; b.Rt = 9; b.Read_data1 = 32'hDEAD; b.Imm = 32'h777;
        step();
        b.Wb_reg_write = 1; b.Wb_write_reg = 5; b.Wb_write_data = 32'hA5D604;
        step();
        b.Wb_reg_write = 0;
        step();
        chk("stall_data1", 64'(b.Ex_data1), 64'hA5D604);
        chk("stall_data2", 64'(b.Ex_data2), 64'h60);
        chk("stall_rs", 64'(b.Ex_rs), 64'd5);
        chk("stall_imm", 64'(b.Ex_imm), 64'hABC);
        chk("stall_valid", 64'(b.Ex_valid), 64'd1);

        // stall outranks load-use; bubble follows once released
        load_lw(5'd1, 5'd2);
        idle();
        b.Stall = 1; b.In_valid = 1; b.Rs = 2;
        step();
        chk("stall_lu_count", 64'(b.Bubble_count), 64'd1);
        chk("stall_lu_valid", 64'(b.Ex_valid), 64'd1);
        b.Stall = 0;
        step();
        chk("bubble_after_stall", 64'(b.Bubble_count), 64'd2);

        // flush outranks load-use
        load_lw(5'd3, 5'd2);
        idle();
        b.In_valid = 1; b.Rs = 2; b.Flush = 1;
        #1;
        chk("flush_lu_asserted", 64'(b.Load_use_stall), 64'd1);
        step();
        chk("flush_valid", 64'(b.Ex_valid), 64'd0);
        chk("flush_count", 64'(b.Bubble_count), 64'd2);
        chk("flush_rt_held", 64'(b.Ex_rt), 64'd2);

        // reset mid-stall
        idle();
        b.In_valid = 1; b.Rs = 4; b.Rt = 5; b.Read_data1 = 32'h9; b.Reg_dst = 1; b.Rd = 6; b.Reg_write = 1;
        step();
        b.Stall = 1; Rst_n = 0;
        step();
        chk("rst_mid_valid", 64'(b.Ex_valid), 64'd0);
        chk("rst_mid_data1", 64'(b.Ex_data1), 64'd0);
        chk("rst_mid_dest", 64'(b.Ex_dest), 64'd0);
        chk("rst_mid_ctrl", 64'(ex_ctrl()), 64'd0);
        chk("rst_mid_count", 64'(b.Bubble_count), 64'd0);
        Rst_n = 1;
        idle();
        b.In_valid = 1; b.Rs = 5; b.Rt = 5;
        #1;
        chk("rst_mid_lu", 64'(b.Load_use_stall), 64'd0);

        // mixed vectors checked by the model
        for (int i = 0; i < 16; i++) begin
            idle();
            b.In_valid = (i % 4) != 3;
            b.Rs = 5'((i * 3) % 32);
            b.Rt = 5'((i * 7 + 1) % 32);
            b.Rd = 5'(i + 10);
            b.Read_data1 = 32'h1000 + i;
            b.Read_data2 = 32'h2000 + i;
            b.Imm = 32'hFFFF_FF00 | i;
            b.Reg_dst = i[0];
            b.Mem_read = (i % 5) == 0;
            b.Mem_write = (i % 6) == 1;
            b.Reg_write = 1;
            b.Alu_op = 4'(i);
            b.Wb_reg_write = i[1];
            b.Wb_write_reg = i[0] ? b.Rt : b.Rs;
            b.Wb_write_data = 32'hBEEF_0000 + i;
            b.Stall = (i % 7) == 4;
            b.Flush = (i % 9) == 8;
            step();
        end
        idle();
        step();

        // counter saturation on the narrow-counter instance
        s_rst_n = 1;
        s.In_valid = 1; s.Mem_read = 1; s.Reg_write = 1; s.Rs = 2; s.Rt = 2;
        for (int k = 0; k < 14; k++) step();
        chk("sat_mid_count", 64'(s.Bubble_count), 64'd7);
        for (int k = 0; k < 26; k++) step();
        chk("sat_count", 64'(s.Bubble_count), 64'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
